// File: rtl/hwpf_pkg.sv
// Shared types and helpers for the hardware prefetch arbitration path.
// The request payload mirrors the hpdcache request port fields the arbiter drives.
package hwpf_pkg;

  localparam int unsigned HWPF_ADDR_W     = 40;
  localparam int unsigned HWPF_LINE_BYTES = 64;
  localparam int unsigned HWPF_OFF_W      = $clog2(HWPF_LINE_BYTES);
  localparam int unsigned HWPF_LINE_W     = HWPF_ADDR_W - HWPF_OFF_W;
  localparam int unsigned HWPF_OP_W       = 4;
  localparam int unsigned HWPF_SID_W      = 3;
  localparam int unsigned HWPF_TID_W      = 6;

  localparam logic [HWPF_OP_W-1:0] HWPF_OP_PREFETCH = 4'h6;

  typedef logic [HWPF_LINE_W-1:0] hwpf_line_t;

  typedef struct packed {
    logic       valid;
    hwpf_line_t line;
  } hwpf_arb_hist_t;

  typedef struct packed {
    logic [HWPF_ADDR_W-1:0] addr;
    logic [HWPF_OP_W-1:0]   op;
    logic [HWPF_SID_W-1:0]  sid;
    logic [HWPF_TID_W-1:0]  tid;
    logic                   need_rsp;
    logic                   uncacheable;
  } hpdcache_req_t;

  // Line number of a byte address; off_w is log2 of the line size.
  function automatic hwpf_line_t hwpf_line(input logic [HWPF_ADDR_W-1:0] addr,
                                           input int unsigned off_w);
    return hwpf_line_t'(addr >> off_w);
  endfunction

endpackage

// File: rtl/hwpf_rr_picker.sv
// Rotate-priority picker: first set request at or after ptr, wrapping modulo N.
// Returns a one-hot grant plus its binary index; purely combinational.
module hwpf_rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_valid
);

  logic [IDX_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any_valid = |req;
    gnt_idx   = '0;
    pos       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (pos >= (IDX_W + 1)'(N)) begin
        pos = pos - (IDX_W + 1)'(N);
      end
      if (req[pos[IDX_W-1:0]]) begin
        gnt_idx = pos[IDX_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = any_valid && (gnt_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/hwpf_arbiter.sv
// Shares the hpdcache prefetch port among NUM_REQ engines: round-robin grant,
// recent-line filter, programmable issue gap and a one-entry output slot.
module hwpf_arbiter
  import hwpf_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = HWPF_ADDR_W,
  parameter int unsigned LINE_BYTES = HWPF_LINE_BYTES,
  parameter int unsigned HIST_DEPTH = 8,
  parameter int unsigned GAP_W      = 4,
  parameter int unsigned PF_SID     = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      lock_i,
  input  logic [GAP_W-1:0]          gap_cfg_i,
  input  logic [NUM_REQ-1:0]        pf_valid_i,
  output logic [NUM_REQ-1:0]        pf_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] pf_addr_i,
  output logic                      dcache_req_valid_o,
  input  logic                      dcache_req_ready_i,
  output hpdcache_req_t             dcache_req_o,
  output logic [31:0]               drop_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned HP_W  = $clog2(HIST_DEPTH);

  logic                 slot_valid_reg, slot_valid_next;
  hpdcache_req_t        slot_req_reg, slot_req_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
  logic [HP_W-1:0]      hist_wp_reg, hist_wp_next;
  hwpf_arb_hist_t       hist_reg [HIST_DEPTH];
  hwpf_arb_hist_t       hist_next [HIST_DEPTH];
  logic [31:0]          drop_cnt_reg, drop_cnt_next;

  hwpf_line_t           req_line [NUM_REQ];
  hwpf_line_t           win_line;
  hwpf_line_t           slot_line;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic [HIST_DEPTH-1:0] hist_match;
  logic                 slot_drain;
  logic                 slot_hit;
  logic                 hit;
  logic                 can_grant;
  logic                 grant;
  hpdcache_req_t        new_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_line
    assign req_line[gi] = hwpf_line(pf_addr_i[gi*ADDR_W +: ADDR_W], OFF_W);
  end

  hwpf_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (pf_valid_i),
    .ptr       (rr_ptr_reg),
    .gnt       (gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any_valid (gnt_any)
  );

  assign win_line  = req_line[gnt_idx];
  assign slot_line = hwpf_line(slot_req_reg.addr, OFF_W);

  for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_cmp
    assign hist_match[gi] = hist_reg[gi].valid && (hist_reg[gi].line == win_line);
  end

  assign slot_drain = slot_valid_reg & dcache_req_ready_i;
  assign slot_hit   = slot_valid_reg & ~slot_drain & (slot_line == win_line);
  assign hit        = (|hist_match) | slot_hit;
  assign can_grant  = ~flush_i & ~lock_i & (gap_cnt_reg == '0)
                    & (~slot_valid_reg | dcache_req_ready_i);
  // Reset is folded in so no engine sees an acceptance while the block is held in reset.
  assign grant      = can_grant & gnt_any & ~rst_i;

  assign pf_ready_o         = grant ? gnt_onehot : '0;
  assign dcache_req_valid_o = slot_valid_reg;
  assign dcache_req_o       = slot_req_reg;
  assign drop_cnt_o         = drop_cnt_reg;

  always_comb begin
    new_req             = '0;
    new_req.addr        = HWPF_ADDR_W'(ADDR_W'(win_line) << OFF_W);
    new_req.op          = HWPF_OP_PREFETCH;
    new_req.sid         = HWPF_SID_W'(PF_SID);
    new_req.tid         = HWPF_TID_W'(gnt_idx);
    new_req.need_rsp    = 1'b0;
    new_req.uncacheable = 1'b0;
  end

  always_comb begin
    slot_valid_next = slot_valid_reg;
    slot_req_next   = slot_req_reg;
    rr_ptr_next     = rr_ptr_reg;
    gap_cnt_next    = gap_cnt_reg;
    hist_wp_next    = hist_wp_reg;
    hist_next       = hist_reg;
    drop_cnt_next   = drop_cnt_reg;

    if (flush_i) begin
      // A handshake in the flush cycle completes; otherwise the request is withdrawn.
      slot_valid_next = 1'b0;
      rr_ptr_next     = '0;
      gap_cnt_next    = '0;
      hist_wp_next    = '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_next[i].valid = 1'b0;
      end
    end else begin
      if (slot_drain) begin
        slot_valid_next = 1'b0;
      end
      if (gap_cnt_reg != '0) begin
        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
      end
      if (grant) begin
        rr_ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      if (grant && hit && (drop_cnt_reg != '1)) begin
        drop_cnt_next = drop_cnt_reg + 32'd1;
      end
      if (grant && !hit) begin
        slot_valid_next        = 1'b1;
        slot_req_next          = new_req;
        hist_next[hist_wp_reg] = '{valid: 1'b1, line: win_line};
        hist_wp_next           = hist_wp_reg + HP_W'(1);
        gap_cnt_next           = gap_cfg_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_valid_reg <= 1'b0;
      slot_req_reg   <= '0;
      rr_ptr_reg     <= '0;
      gap_cnt_reg    <= '0;
      hist_wp_reg    <= '0;
      drop_cnt_reg   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_reg[i] <= '0;
      end
    end else begin
      slot_valid_reg <= slot_valid_next;
      slot_req_reg   <= slot_req_next;
      rr_ptr_reg     <= rr_ptr_next;
      gap_cnt_reg    <= gap_cnt_next;
      hist_wp_reg    <= hist_wp_next;
      drop_cnt_reg   <= drop_cnt_next;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_reg[i] <= hist_next[i];
      end
    end
  end

endmodule
